// File: rtl/dmul_pkg.sv
// Shared definitions for the credit-guarded double-precision multiply stage.
// Holds the data width, the FLUSH/RUN state encoding, the occupancy-width
// helper and the parameter legality check used at elaboration of the top.
package dmul_pkg;

  localparam int DMUL_DATA_W  = 64;
  localparam int DMUL_LAT_MIN = 1;
  localparam int DMUL_LAT_MAX = 5;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } dmul_state_t;

  // Width that can hold every value 0..depth.
  function automatic int dmul_occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // LATENCY within the supported core range, FIFO_DEPTH a power of two with
  // room for a full pipeline plus one.
  function automatic bit dmul_cfg_ok(input int latency, input int depth);
    return (latency >= DMUL_LAT_MIN) && (latency <= DMUL_LAT_MAX) &&
           (depth >= latency + 1) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dmul_core.sv
// Behavioural stand-in for the vendor fixed-latency binary64 multiplier.
// Ports: clk (no reset: pipeline contents are undefined after power-up);
// s_tvalid_i/s_a_i/s_b_i operand beat; m_tready_i advances the pipeline
// (tied 1 by the wrapper, so the core never stalls); m_tvalid_o/m_tdata_o
// product LATENCY cycles after the operand beat.
// Arithmetic: round-to-nearest-even, subnormal inputs and outputs flushed to
// signed zero, any NaN result is the canonical quiet NaN 0x7FF8...0.
module dmul_core #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        s_tvalid_i,
  input  logic [63:0] s_a_i,
  input  logic [63:0] s_b_i,
  input  logic        m_tready_i,
  output logic        m_tvalid_o,
  output logic [63:0] m_tdata_o
);

  logic [63:0]  res;
  logic         sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [105:0] prod;
  logic [51:0]  mant, mant_r;
  logic         guard, sticky, norm, carry;
  logic [12:0]  e_sum;

  always_comb begin
    sgn    = s_a_i[63] ^ s_b_i[63];
    a_nan  = (s_a_i[62:52] == 11'h7ff) && (s_a_i[51:0] != '0);
    b_nan  = (s_b_i[62:52] == 11'h7ff) && (s_b_i[51:0] != '0);
    a_inf  = (s_a_i[62:52] == 11'h7ff) && (s_a_i[51:0] == '0);
    b_inf  = (s_b_i[62:52] == 11'h7ff) && (s_b_i[51:0] == '0);
    a_zero = (s_a_i[62:52] == 11'h000);
    b_zero = (s_b_i[62:52] == 11'h000);
    prod   = 106'({1'b1, s_a_i[51:0]}) * 106'({1'b1, s_b_i[51:0]});
    // Product of two [1,2) significands lies in [1,4): bit 105 says which.
    norm   = prod[105];
    if (norm) begin
      mant   = prod[104:53];
      guard  = prod[52];
      sticky = |prod[51:0];
    end else begin
      mant   = prod[103:52];
      guard  = prod[51];
      sticky = |prod[50:0];
    end
    {carry, mant_r} = {1'b0, mant} + 53'(guard & (sticky | mant[0]));
    // Biased sum carries an extra +1023; result exponent = e_sum - 1023.
    e_sum = 13'(s_a_i[62:52]) + 13'(s_b_i[62:52]) + 13'(norm) + 13'(carry);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      res = 64'h7FF8_0000_0000_0000;
    else if (a_inf || b_inf)
      res = {sgn, 11'h7ff, 52'h0};
    else if (a_zero || b_zero)
      res = {sgn, 63'h0};
    else if (e_sum >= 13'd3070)
      res = {sgn, 11'h7ff, 52'h0};
    else if (e_sum <= 13'd1023)
      res = {sgn, 63'h0};
    else
      res = {sgn, 11'(e_sum - 13'd1023), mant_r};
  end

  logic [LATENCY-1:0] vld_q;
  logic [63:0]        dat_q [LATENCY];

  always_ff @(posedge clk) begin
    if (m_tready_i) begin
      vld_q[0] <= s_tvalid_i;
      dat_q[0] <= res;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign m_tvalid_o = vld_q[LATENCY-1] & m_tready_i;
  assign m_tdata_o  = dat_q[LATENCY-1];

endmodule

// File: rtl/dmul_result_fifo.sv
// Synchronous first-word-fall-through FIFO for multiplier results.
// Ports: clk, rst (sync, active high); wr_en_i/wr_data_i write side;
// rd_en_i pops the head; rd_data_o shows the head (0 when empty);
// count_o is the number of stored entries. The writer never writes when full
// and the reader never pops when empty; full/empty come from count_o only.
module dmul_result_fifo import dmul_pkg::*; #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [W-1:0]                 wr_data_i,
  input  logic                         rd_en_i,
  output logic [W-1:0]                 rd_data_o,
  output logic [dmul_occ_w(DEPTH)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = dmul_occ_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
    end
  end

  assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/dmul_axis_credit.sv
// Backpressure-safe binary64 multiply stage: joins AXI-Stream operands A and
// B, issues them into a fixed-latency core with no backpressure, and buffers
// products in a FIFO guarded by credits so result_tready is fully honoured.
// Optional feature macro: DMUL_TAG_EN adds a_tuser/result_tuser and a tag
// delay line carried alongside the core.
// Ports: clk, rst (sync, active high); a_*/b_* operand channels;
// result_* product channel; busy (FLUSH or anything in flight/buffered);
// align_err (sticky core-valid vs expected-valid disagreement);
// dbg_state (current FLUSH/RUN state).
//
// Handshakes: a beat transfers in a cycle where tvalid and tready are both 1.
// Sources hold tvalid and data steady until the transfer; A and B transfer
// together only (each tready depends on the other's tvalid, never on its own),
// and result data is held stable while result_tvalid=1 and result_tready=0.
module dmul_axis_credit import dmul_pkg::*; #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_tvalid,
  input  logic [DMUL_DATA_W-1:0] a_tdata,
`ifdef DMUL_TAG_EN
  input  logic [TAG_W-1:0]       a_tuser,
`endif
  output logic                   a_tready,
  input  logic                   b_tvalid,
  input  logic [DMUL_DATA_W-1:0] b_tdata,
  output logic                   b_tready,
  output logic                   result_tvalid,
  output logic [DMUL_DATA_W-1:0] result_tdata,
`ifdef DMUL_TAG_EN
  output logic [TAG_W-1:0]       result_tuser,
`endif
  input  logic                   result_tready,
  output logic                   busy,
  output logic                   align_err,
  output dmul_state_t            dbg_state
);

  localparam int OCC_W = dmul_occ_w(FIFO_DEPTH);
  localparam int DRN_W = $clog2(DMUL_LAT_MAX + 1);
`ifdef DMUL_TAG_EN
  localparam int ENT_W = DMUL_DATA_W + TAG_W;
`else
  localparam int ENT_W = DMUL_DATA_W;
`endif

  if (!(dmul_cfg_ok(LATENCY, FIFO_DEPTH) && (TAG_W > 0))) begin : g_cfg_err
    $error("dmul_axis_credit: illegal LATENCY/FIFO_DEPTH/TAG_W combination");
  end

  dmul_state_t            state_q, state_d;
  logic [DRN_W-1:0]       drain_q, drain_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [LATENCY-1:0]     expv_q;
  logic                   align_err_q, align_err_d;
  logic                   run, credit_ok, fire, pop, core_v, exp_tail, fifo_wr;
  logic [DMUL_DATA_W-1:0] core_data;
  logic [ENT_W-1:0]       fifo_wdata, fifo_rdata;
  logic [OCC_W-1:0]       fifo_cnt;

  // occ counts in-flight plus buffered results, so a credit is reserved at
  // issue time and the FIFO can never be written while full.
  assign run       = (state_q == RUN) & ~rst;
  assign credit_ok = occ_q < OCC_W'(FIFO_DEPTH);
  assign a_tready  = run & credit_ok & b_tvalid;
  assign b_tready  = run & credit_ok & a_tvalid;
  assign fire      = run & credit_ok & a_tvalid & b_tvalid;
  assign result_tvalid = (fifo_cnt != '0);
  assign pop       = result_tvalid & result_tready;
  assign exp_tail  = expv_q[LATENCY-1];
  // The expected-valid line decides the write so a misbehaving core cannot
  // corrupt the credit accounting; disagreement only raises align_err.
  assign fifo_wr   = (state_q == RUN) & exp_tail;
  assign busy      = (state_q == FLUSH) | (occ_q != '0);
  assign align_err = align_err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    occ_d       = occ_q;
    align_err_d = align_err_q;
    case (state_q)
      // The core has no reset: wait out one full pipeline of stale beats.
      FLUSH: begin
        if (drain_q == DRN_W'(LATENCY - 1)) begin
          state_d = RUN;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      RUN: begin
        if (core_v != exp_tail) align_err_d = 1'b1;
      end
      default: state_d = FLUSH;
    endcase
    case ({fire, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FLUSH;
      drain_q     <= '0;
      occ_q       <= '0;
      expv_q      <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      occ_q       <= occ_d;
      expv_q      <= LATENCY'({expv_q, fire});
      align_err_q <= align_err_d;
    end
  end

  dmul_core #(.LATENCY(LATENCY)) u_core (
    .clk        (clk),
    .s_tvalid_i (fire),
    .s_a_i      (a_tdata),
    .s_b_i      (b_tdata),
    .m_tready_i (1'b1),
    .m_tvalid_o (core_v),
    .m_tdata_o  (core_data)
  );

`ifdef DMUL_TAG_EN
  // Tags ride a delay line matched to the core; only slots marked in
  // expv_q are ever written into the FIFO, so no reset is needed here.
  logic [TAG_W-1:0] tag_dl_q [LATENCY];

  always_ff @(posedge clk) begin
    tag_dl_q[0] <= a_tuser;
    for (int i = 1; i < LATENCY; i++) tag_dl_q[i] <= tag_dl_q[i-1];
  end

  assign fifo_wdata   = {tag_dl_q[LATENCY-1], core_data};
  assign result_tuser = fifo_rdata[ENT_W-1:DMUL_DATA_W];
`else
  assign fifo_wdata = core_data;
`endif
  assign result_tdata = fifo_rdata[DMUL_DATA_W-1:0];

  dmul_result_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_cnt)
  );

endmodule

// File: doc/dmul_axis_credit.md
# dmul_axis_credit

Backpressure-safe, parametrised double-precision multiply stage. It joins two AXI-Stream operand channels and issues products into a fixed-latency vendor multiplier core that has no backpressure. Results are buffered in a credit-guarded result FIFO, so `result_tready` is fully honoured. It sits in the FP datapath wherever a multiplier output feeds a consumer that can stall.

## Interface
- `LATENCY`, 2: core pipeline latency in cycles; legal range 1..5; selects the core configuration.
- `FIFO_DEPTH`, 8: result FIFO entries; power of two; must be at least LATENCY+1.
- `TAG_W`, 8: sideband tag width; used only with `DMUL_TAG_EN`.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `a_tvalid` in 1, `a_tdata` in 64, `a_tready` out 1: operand A, IEEE-754 binary64.
- `a_tuser` in TAG_W: tag accompanying A; present only with `DMUL_TAG_EN`.
- `b_tvalid` in 1, `b_tdata` in 64, `b_tready` out 1: operand B, binary64.
- `result_tvalid` out 1, `result_tdata` out 64, `result_tready` in 1: product A×B.
- `result_tuser` out TAG_W: tag returned with the product; present only with `DMUL_TAG_EN`.
- `busy` out 1: high when any operation is in flight or buffered, and during FLUSH.
- `align_err` out 1: sticky flag; core output valid disagreed with the expected-valid shift register.

## Operation
- **FSM states:** FLUSH and RUN. Reset enters FLUSH.
- **FLUSH:**
  - Lasts exactly LATENCY cycles, counted by a drain counter.
  - Core output valids are discarded, because the core has no reset and its in-flight data is stale.
  - Both readies are held 0.
  - Then transitions to RUN.
- **Occupancy counter:** `occ` is clog2(FIFO_DEPTH+1) bits wide and equals in-flight count plus FIFO count.
  - `credit_ok = (occ < FIFO_DEPTH)`.
- **Issue (RUN only):**
  - `fire = a_tvalid & b_tvalid & credit_ok`.
  - `a_tready = credit_ok & b_tvalid`; `b_tready = credit_ok & a_tvalid`. Both readies assert in the same cycle; no operand is consumed singly.
  - On fire, the core is driven with tvalid=1, the A and B data, and a 1 is shifted into the expected-valid register. With the macro, the tag is shifted alongside.
- **Completion:**
  - The core output valid writes data (and tag) into the FIFO.
  - If core valid differs from the expected-valid register tail, `align_err` is set and held until reset. The FIFO is written only when the expected valid is 1.
- **Pop:** `result_tvalid & result_tready`.
- **Occupancy update:**
  - +1 on fire, −1 on pop, unchanged on simultaneous fire and pop.
  - Credits guarantee the FIFO never overflows, so no write-when-full path exists.
- **Arithmetic:** the product is core-defined (round-to-nearest-even, with vendor NaN/Inf/subnormal handling). The block does not alter the data.
- **`busy`:** `(state==FLUSH) | (occ != 0)`.

## Timing
- **Reset values:** `result_tvalid`=0, `result_tdata`=0, `result_tuser`=0, `a_tready`=`b_tready`=0 (also forced 0 while `rst`=1), `busy`=1, `align_err`=0, `occ`=0, FIFO empty.
- **Reset mid-operation:** all in-flight and buffered results are dropped; FLUSH is re-entered.
- **First ready:** readies can first assert on cycle LATENCY+1 after `rst` falls.
- **Latency:** a fire in cycle t gives `result_tvalid`=1 in cycle t+LATENCY+1 (one extra cycle for the FIFO write), when the FIFO was empty.
- **Throughput:** 1 result per cycle with `result_tready` held 1.
- **FIFO:** registered first-word-fall-through. Head data is stable while `result_tvalid`=1 and `result_tready`=0.
- **Stalled consumer:** at most FIFO_DEPTH fires occur, then readies drop in the cycle `occ` reaches FIFO_DEPTH.
  - A pop in cycle t re-enables readies in cycle t+1 (occ is registered).
- **FIFO pointers:** clog2(FIFO_DEPTH) bits, wrap naturally.
  - Full/empty are distinguished by a separate count, not by pointer equality.

## Configuration
- **`DMUL_TAG_EN` defined:**
  - `a_tuser` and `result_tuser` ports exist.
  - A TAG_W-wide, LATENCY-deep tag delay line is built.
  - FIFO entries are 64+TAG_W bits.
- **`DMUL_TAG_EN` undefined:** tuser ports, tag delay line and tag FIFO storage are absent; FIFO entries are 64 bits. All other behaviour is identical.

## Structure
- **Package `dmul_pkg`:**
  - `DMUL_DATA_W`=64.
  - `dmul_state_t` enum {FLUSH, RUN}.
  - Function `dmul_occ_w(depth)` returning clog2(depth+1).
  - `DMUL_LAT_MIN`=1, `DMUL_LAT_MAX`=5.
  - Elaboration check for the LATENCY and FIFO_DEPTH legality rules.
- **Sub-module `dmul_result_fifo`:** parametrised width and depth, synchronous FWFT FIFO with count output.
- **Core:** the vendor multiplier configuration selected by LATENCY is instantiated directly; its tready input is tied 1.

## Test plan
- **Single product, LATENCY=2:** A=0x4000000000000000 (2.0), B=0x4008000000000000 (3.0), fire at t → `result_tdata`=0x4018000000000000 (6.0) with `result_tvalid` at t+3.
- **Consumer stalled:** `result_tready`=0, 12 operand pairs offered back-to-back, FIFO_DEPTH=8 → exactly 8 fires, readies low thereafter. One pop re-enables readies the next cycle. All 8 results are drained in order.
- **Join:** `a_tvalid`=1 and `b_tvalid`=0 for 5 cycles → `a_tready`=0, no fire. Raising `b_tvalid` fires the same cycle.
- **Reset mid-flight:** 3 operations issued, `rst` pulsed 1 cycle → no result ever appears, `busy`=1 for LATENCY cycles then 0, readies return on cycle LATENCY+1.
- **Tag (`DMUL_TAG_EN`):** tags 0x11, 0x22, 0x33 on consecutive fires with random `result_tready` → results return in order with `result_tuser` 0x11, 0x22, 0x33.
- **Special values:** 1.0×Inf (0x7FF0000000000000) → 0x7FF0000000000000. 0×Inf → quiet NaN (exponent all ones, mantissa≠0). `align_err` stays 0 throughout all tests.
